// File: rtl/axis_multi_dispatcher.sv
// Multi-channel AXI-Stream dispatcher: per-channel FIFOs merged onto one tx port by a
// round-robin arbiter with optional packet locking; beats tagged with tid/tdest, tuser above tdata.
module axis_multi_dispatcher #(
    parameter int DATAW       = 512,
    parameter int USERW       = 75,
    parameter int IDW         = 2,
    parameter int DESTW       = 4,
    parameter int NUM_CH      = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int PACKET_MODE = 1,
    parameter logic [NUM_CH*DESTW-1:0] DEST_NODES = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         wr_en,
    input  logic [NUM_CH-1:0]         wr_last,
    input  logic [NUM_CH*DATAW-1:0]   wr_data,
    input  logic [NUM_CH*USERW-1:0]   wr_user,
    output logic [NUM_CH-1:0]         wr_rdy,
    output logic [NUM_CH-1:0]         wr_ovf,
    output logic                      axis_tx_tvalid,
    input  logic                      axis_tx_tready,
    output logic [DATAW+USERW-1:0]    axis_tx_tdata,
    output logic                      axis_tx_tlast,
    output logic [IDW-1:0]            axis_tx_tid,
    output logic [DESTW-1:0]          axis_tx_tdest
);

    localparam int FW   = DATAW + USERW + 1;
    localparam int TW   = DATAW + USERW;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NPAD = 2 ** IDW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    generate
        if (NUM_CH < 1 || NUM_CH > NPAD) begin : g_bad_ch
            $error("axis_multi_dispatcher: NUM_CH must be in 1..2**IDW");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("axis_multi_dispatcher: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} arb_state_t;

    logic [NUM_CH-1:0]  push_s;
    logic [NUM_CH-1:0]  pop_s;
    logic [NPAD-1:0]    empty_s;
    logic [FW-1:0]      head_s [NUM_CH];
    logic [NUM_CH-1:0]  wr_rdy_r;
    logic [NUM_CH-1:0]  wr_ovf_r;

    arb_state_t         state_r;
    logic [IDW-1:0]     lock_ch_r;
    logic [IDW-1:0]     rr_ptr_r;
    logic               tvalid_r;
    logic [TW-1:0]      tdata_r;
    logic               tlast_r;
    logic [IDW-1:0]     tid_r;
    logic [DESTW-1:0]   tdest_r;

    logic               sel_found_s;
    logic [IDW-1:0]     sel_ch_s;
    logic [IDW-1:0]     scan_s;
    logic [FW-1:0]      sel_head_s;
    logic [DESTW-1:0]   sel_dest_s;
    logic               load_s;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] ch);
        logic [IDW-1:0] nxt;
        if (ch >= IDW'(NUM_CH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ch + IDW'(1);
        end
        return nxt;
    endfunction

    generate
        if (NUM_CH < NPAD) begin : g_pad
            assign empty_s[NPAD-1:NUM_CH] = '1;
        end

        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [FW-1:0] mem_r [FIFO_DEPTH];
            logic [AW-1:0] wr_ptr_r;
            logic [AW-1:0] rd_ptr_r;
            logic [AW:0]   count_r;
            logic [AW:0]   count_nxt_s;

            assign push_s[c]  = wr_en[c] & wr_rdy_r[c];
            assign pop_s[c]   = load_s & (sel_ch_s == IDW'(c));
            assign empty_s[c] = (count_r == '0);
            assign head_s[c]  = mem_r[rd_ptr_r];

            // Occupancy after this edge; drives the registered ready
            always_comb begin
                if (push_s[c] && !pop_s[c]) begin
                    count_nxt_s = count_r + (AW+1)'(1);
                end else if (!push_s[c] && pop_s[c]) begin
                    count_nxt_s = count_r - (AW+1)'(1);
                end else begin
                    count_nxt_s = count_r;
                end
            end

            // Beat storage
            always_ff @(posedge clk) begin
                if (push_s[c]) begin
                    mem_r[wr_ptr_r] <= {wr_last[c], wr_user[c*USERW +: USERW], wr_data[c*DATAW +: DATAW]};
                end
            end

            // Pointers, occupancy, ready and sticky overflow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_r    <= '0;
                    rd_ptr_r    <= '0;
                    count_r     <= '0;
                    wr_rdy_r[c] <= 1'b0;
                    wr_ovf_r[c] <= 1'b0;
                end else begin
                    if (push_s[c]) begin
                        wr_ptr_r <= wr_ptr_r + AW'(1);
                    end
                    if (pop_s[c]) begin
                        rd_ptr_r <= rd_ptr_r + AW'(1);
                    end
                    count_r     <= count_nxt_s;
                    wr_rdy_r[c] <= (count_nxt_s < DEPTH_C);
                    if (wr_en[c] && !wr_rdy_r[c]) begin
                        wr_ovf_r[c] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Channel selection: locked channel only, else first non-empty at/after rr_ptr
    always_comb begin
        sel_found_s = 1'b0;
        sel_ch_s    = rr_ptr_r;
        scan_s      = rr_ptr_r;
        case (state_r)
            ST_LOCKED: begin
                sel_ch_s    = lock_ch_r;
                sel_found_s = ~empty_s[lock_ch_r];
            end
            ST_IDLE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!sel_found_s && !empty_s[scan_s]) begin
                        sel_found_s = 1'b1;
                        sel_ch_s    = scan_s;
                    end else begin
                        sel_found_s = sel_found_s;
                    end
                    scan_s = wrap_inc(scan_s);
                end
            end
            default: begin
                sel_found_s = 1'b0;
                sel_ch_s    = rr_ptr_r;
            end
        endcase
    end

    // Head beat and destination of the selected channel
    always_comb begin
        sel_head_s = '0;
        sel_dest_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_ch_s == IDW'(c)) begin
                sel_head_s = head_s[c];
                sel_dest_s = DEST_NODES[c*DESTW +: DESTW];
            end else begin
                sel_head_s = sel_head_s;
                sel_dest_s = sel_dest_s;
            end
        end
    end

    assign load_s = (~tvalid_r | axis_tx_tready) & sel_found_s;

    // Arbiter state, round-robin pointer and the single output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            lock_ch_r <= '0;
            rr_ptr_r  <= '0;
            tvalid_r  <= 1'b0;
            tdata_r   <= '0;
            tlast_r   <= 1'b0;
            tid_r     <= '0;
            tdest_r   <= '0;
        end else begin
            if (load_s) begin
                tvalid_r <= 1'b1;
                tdata_r  <= sel_head_s[TW-1:0];
                tlast_r  <= sel_head_s[FW-1];
                tid_r    <= sel_ch_s;
                tdest_r  <= sel_dest_s;
                rr_ptr_r <= wrap_inc(sel_ch_s);
                if (PACKET_MODE != 0 && !sel_head_s[FW-1]) begin
                    state_r   <= ST_LOCKED;
                    lock_ch_r <= sel_ch_s;
                end else begin
                    state_r   <= ST_IDLE;
                end
            end else if (axis_tx_tready) begin
                tvalid_r <= 1'b0;
            end
        end
    end

    assign wr_rdy         = wr_rdy_r;
    assign wr_ovf         = wr_ovf_r;
    assign axis_tx_tvalid = tvalid_r;
    assign axis_tx_tdata  = tdata_r;
    assign axis_tx_tlast  = tlast_r;
    assign axis_tx_tid    = tid_r;
    assign axis_tx_tdest  = tdest_r;

endmodule

// File: tb/tb_axis_multi_dispatcher.sv
// Self-checking bench: two dispatchers (packet mode and beat mode) share stimulus and are
// compared each cycle against a queue-based model of the channel/arbitration rules.
module tb_axis_multi_dispatcher;

    localparam int DATAW = 512;
    localparam int USERW = 75;
    localparam int IDW   = 2;
    localparam int DESTW = 4;
    localparam int NCH   = 3;
    localparam int DEPTH = 8;
    localparam int TW    = DATAW + USERW;
    localparam int FW    = TW + 1;
    localparam int W     = 640;
    localparam logic [NCH*DESTW-1:0] DEST = {4'd9, 4'd5, 4'd2};

    logic clk = 1'b0;
    logic rst_n;
    logic [NCH-1:0] wr_en, wr_last;
    logic [NCH*DATAW-1:0] wr_data;
    logic [NCH*USERW-1:0] wr_user;
    logic tready;

    logic [NCH-1:0] rdy0, ovf0, rdy1, ovf1;
    logic tvalid0, tvalid1, tlast0, tlast1;
    logic [TW-1:0] tdata0, tdata1;
    logic [IDW-1:0] tid0, tid1;
    logic [DESTW-1:0] tdest0, tdest1;

    always #5 clk = ~clk;

    axis_multi_dispatcher #(.DATAW(DATAW), .USERW(USERW), .IDW(IDW), .DESTW(DESTW), .NUM_CH(NCH),
        .FIFO_DEPTH(DEPTH), .PACKET_MODE(1), .DEST_NODES(DEST)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_last(wr_last), .wr_data(wr_data),
        .wr_user(wr_user), .wr_rdy(rdy0), .wr_ovf(ovf0), .axis_tx_tvalid(tvalid0),
        .axis_tx_tready(tready), .axis_tx_tdata(tdata0), .axis_tx_tlast(tlast0),
        .axis_tx_tid(tid0), .axis_tx_tdest(tdest0));

    axis_multi_dispatcher #(.DATAW(DATAW), .USERW(USERW), .IDW(IDW), .DESTW(DESTW), .NUM_CH(NCH),
        .FIFO_DEPTH(DEPTH), .PACKET_MODE(0), .DEST_NODES(DEST)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_last(wr_last), .wr_data(wr_data),
        .wr_user(wr_user), .wr_rdy(rdy1), .wr_ovf(ovf1), .axis_tx_tvalid(tvalid1),
        .axis_tx_tready(tready), .axis_tx_tdata(tdata1), .axis_tx_tlast(tlast1),
        .axis_tx_tid(tid1), .axis_tx_tdest(tdest1));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state, index 0 = packet mode, 1 = beat mode
    logic [FW-1:0] mq [2][NCH][$];
    bit            m_valid [2];
    logic [TW-1:0] m_data [2];
    bit            m_last [2];
    int            m_tid [2];
    int            m_rr [2];
    bit            m_locked [2];
    int            m_lock [2];
    logic [NCH-1:0] m_rdy [2];
    logic [NCH-1:0] m_ovf [2];

    // beats observed leaving each DUT
    int            log_tid [2][$];
    int            log_dest [2][$];
    int            log_cyc [2][$];
    logic [TW-1:0] log_data [2][$];
    logic [TW-1:0] sent_q [$];
    int            exp_q [$];

    task automatic chk(input string name, input int d, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) mq[d][c].delete();
            m_valid[d] = 1'b0; m_data[d] = '0; m_last[d] = 1'b0; m_tid[d] = 0;
            m_rr[d] = 0; m_locked[d] = 1'b0; m_lock[d] = 0;
            m_rdy[d] = '0; m_ovf[d] = '0;
        end
    endtask

    // state after the coming posedge, from current inputs
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            bit found;
            int ch;
            logic [FW-1:0] w;
            found = 1'b0;
            ch = 0;
            if (!m_valid[d] || tready) begin
                if (m_locked[d]) begin
                    ch = m_lock[d];
                    found = (mq[d][ch].size() > 0);
                end else begin
                    for (int i = 0; i < NCH; i++) begin
                        int k;
                        k = (m_rr[d] + i) % NCH;
                        if (!found && mq[d][k].size() > 0) begin
                            found = 1'b1;
                            ch = k;
                        end
                    end
                end
                if (found) begin
                    w = mq[d][ch].pop_front();
                    m_valid[d]  = 1'b1;
                    m_data[d]   = w[TW-1:0];
                    m_last[d]   = w[FW-1];
                    m_tid[d]    = ch;
                    m_rr[d]     = (ch + 1) % NCH;
                    m_locked[d] = (d == 0) && !w[FW-1];
                    m_lock[d]   = ch;
                end else begin
                    m_valid[d] = 1'b0;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (wr_en[c]) begin
                    if (m_rdy[d][c]) mq[d][c].push_back({wr_last[c], wr_user[c*USERW +: USERW], wr_data[c*DATAW +: DATAW]});
                    else m_ovf[d][c] = 1'b1;
                end
            end
            for (int c = 0; c < NCH; c++) m_rdy[d][c] = (mq[d][c].size() < DEPTH);
        end
    endtask

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            logic v, l;
            logic [TW-1:0] dt;
            logic [IDW-1:0] id;
            logic [DESTW-1:0] ds;
            logic [NCH-1:0] r, o;
            v = (d == 0) ? tvalid0 : tvalid1;
            l = (d == 0) ? tlast0 : tlast1;
            dt = (d == 0) ? tdata0 : tdata1;
            id = (d == 0) ? tid0 : tid1;
            ds = (d == 0) ? tdest0 : tdest1;
            r = (d == 0) ? rdy0 : rdy1;
            o = (d == 0) ? ovf0 : ovf1;
            chk("tvalid", d, W'(v), W'(m_valid[d]));
            if (m_valid[d]) begin
                chk("tdata", d, W'(dt), W'(m_data[d]));
                chk("tlast", d, W'(l), W'(m_last[d]));
                chk("tid", d, W'(id), W'(m_tid[d]));
                chk("tdest", d, W'(ds), W'(DEST[m_tid[d]*DESTW +: DESTW]));
            end
            chk("wr_rdy", d, W'(r), W'(m_rdy[d]));
            chk("wr_ovf", d, W'(o), W'(m_ovf[d]));
        end
    endtask

    task automatic cycle();
        model_step();
        if (tvalid0 && tready) begin
            log_tid[0].push_back(int'(tid0)); log_dest[0].push_back(int'(tdest0));
            log_cyc[0].push_back(cyc); log_data[0].push_back(tdata0);
        end
        if (tvalid1 && tready) begin
            log_tid[1].push_back(int'(tid1)); log_dest[1].push_back(int'(tdest1));
            log_cyc[1].push_back(cyc); log_data[1].push_back(tdata1);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            log_tid[d].delete(); log_dest[d].delete(); log_cyc[d].delete(); log_data[d].delete();
        end
    endtask

    task automatic set_beat(input int c, input bit last);
        logic [DATAW-1:0] dv;
        logic [95:0] uv;
        for (int k = 0; k < DATAW / 32; k++) dv[k*32 +: 32] = $urandom;
        uv = {$urandom, $urandom, $urandom};
        wr_en[c] = 1'b1;
        wr_last[c] = last;
        wr_data[c*DATAW +: DATAW] = dv;
        wr_user[c*USERW +: USERW] = uv[USERW-1:0];
        sent_q.push_back({uv[USERW-1:0], dv});
    endtask

    task automatic chk_tids(input string name, input int d);
        chk({name, "_count"}, d, W'(log_tid[d].size()), W'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_tid[d].size(); i++)
            chk(name, d, W'(log_tid[d][i]), W'(exp_q[i]));
    endtask

    initial begin
        rst_n = 1'b0; wr_en = '0; wr_last = '0; wr_data = '0; wr_user = '0; tready = 1'b0;
        model_reset();

        // 1: reset state and release
        repeat (3) @(negedge clk);
        compare();
        chk("rst_tvalid", 0, W'(tvalid0), W'(0));
        chk("rst_rdy", 0, W'(rdy0), W'(0));
        rst_n = 1'b1;
        cycle();
        chk("rdy_after_release", 0, W'(rdy0), W'(3'b111));
        chk("rdy_after_release", 1, W'(rdy1), W'(3'b111));
        tready = 1'b1;
        repeat (4) cycle();

        // 2: one last-beat per channel in the same cycle
        clear_logs();
        set_beat(0, 1'b1); set_beat(1, 1'b1); set_beat(2, 1'b1);
        cycle();
        wr_en = '0;
        chk("latency_not_yet", 0, W'(tvalid0), W'(0));
        cycle();
        chk("latency_valid", 0, W'(tvalid0), W'(1));
        chk("latency_tid", 0, W'(tid0), W'(0));
        repeat (5) cycle();
        exp_q = {0, 1, 2};
        chk_tids("t2_order", 0);
        chk_tids("t2_order", 1);
        exp_q = {2, 5, 9};
        for (int i = 0; i < 3 && i < log_dest[0].size(); i++) chk("t2_tdest", 0, W'(log_dest[0][i]), W'(exp_q[i]));
        if (log_cyc[0].size() == 3) begin
            chk("t2_b2b", 0, W'(log_cyc[0][1] - log_cyc[0][0]), W'(1));
            chk("t2_b2b", 0, W'(log_cyc[0][2] - log_cyc[0][1]), W'(1));
        end

        // 3: slow 4-beat packet on ch0 versus 2 ready beats on ch1
        clear_logs();
        wr_en = '0; set_beat(0, 1'b0); set_beat(1, 1'b0); cycle();
        wr_en = '0; set_beat(1, 1'b1); cycle();
        wr_en = '0; cycle();
        for (int b = 1; b <= 3; b++) begin
            wr_en = '0; set_beat(0, b == 3); cycle();
            wr_en = '0; repeat (2) cycle();
        end
        repeat (6) cycle();
        exp_q = {0, 0, 0, 0, 1, 1};
        chk_tids("t3_packet_lock", 0);

        // 4: backpressure, fill, overflow, drain in order
        clear_logs();
        sent_q.delete();
        tready = 1'b0;
        wr_en = '0; set_beat(0, 1'b1); cycle();
        wr_en = '0; cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t4_hold_valid", 0, W'(tvalid0), W'(1));
            chk("t4_hold_data", 0, W'(tdata0), W'(sent_q[0]));
            chk("t4_hold_tid", 0, W'(tid0), W'(0));
            chk("t4_hold_dest", 0, W'(tdest0), W'(2));
            chk("t4_hold_last", 0, W'(tlast0), W'(1));
        end
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = '0; set_beat(0, 1'b1); cycle();
        end
        chk("t4_full_rdy", 0, W'(rdy0[0]), W'(0));
        chk("t4_ovf_before", 0, W'(ovf0[0]), W'(0));
        wr_en = '0; set_beat(0, 1'b1); void'(sent_q.pop_back()); cycle();
        chk("t4_ovf", 0, W'(ovf0[0]), W'(1));
        chk("t4_ovf", 1, W'(ovf1[0]), W'(1));
        wr_en = '0; tready = 1'b1;
        repeat (12) cycle();
        chk("t4_drain_count", 0, W'(log_data[0].size()), W'(DEPTH + 1));
        chk("t4_drain_count", 1, W'(log_data[1].size()), W'(DEPTH + 1));
        for (int i = 0; i < sent_q.size() && i < log_data[0].size(); i++)
            chk("t4_drain_order", 0, W'(log_data[0][i]), W'(sent_q[i]));

        // 5: three beats on ch0 and ch1; beat mode interleaves, packet mode does not
        wr_en = '0; set_beat(2, 1'b1); cycle();
        wr_en = '0; repeat (3) cycle();
        clear_logs();
        for (int b = 0; b < 3; b++) begin
            wr_en = '0; set_beat(0, b == 2); set_beat(1, b == 2); cycle();
        end
        wr_en = '0;
        repeat (10) cycle();
        exp_q = {0, 1, 0, 1, 0, 1};
        chk_tids("t5_interleave", 1);
        exp_q = {0, 0, 0, 1, 1, 1};
        chk_tids("t5_packets", 0);

        // 6: reset mid-packet with beats buffered
        tready = 1'b0;
        wr_en = '0; set_beat(1, 1'b0); cycle();
        wr_en = '0; set_beat(0, 1'b0); set_beat(1, 1'b0); cycle();
        wr_en = '0; cycle();
        chk("t6_pre_valid", 0, W'(tvalid0), W'(1));
        chk("t6_pre_tid", 0, W'(tid0), W'(1));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_async_valid", 0, W'(tvalid0), W'(0));
        chk("t6_async_valid", 1, W'(tvalid1), W'(0));
        chk("t6_async_rdy", 0, W'(rdy0), W'(0));
        repeat (2) cycle();
        rst_n = 1'b1; tready = 1'b1;
        repeat (4) cycle();
        clear_logs();
        wr_en = '0; set_beat(0, 1'b1); set_beat(2, 1'b1); cycle();
        wr_en = '0;
        repeat (4) cycle();
        exp_q = {0, 2};
        chk_tids("t6_restart", 0);
        chk_tids("t6_restart", 1);

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            wr_en = '0;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 9) < 4) set_beat(c, $urandom_range(0, 2) == 0);
            tready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        wr_en = '0; tready = 1'b1;
        repeat (40) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
